// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
// Shared types and constants for the two-port SDRAM arbiter.
//   arb_state_t  : arbiter FSM states
//   ADDR_W_DEF   : default controller address width
//   DATA_W_DEF   : default controller data width
//   WIDTH_32     : data_width code for a 32-bit access
//   timer_width  : bits needed to count 0..timeout inclusive
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] WIDTH_32 = 2'b10;

    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick
// Combinational two-way round-robin chooser.
//   req[1:0]   : per-port request
//   last_owner : port that finished the previous access
//   valid      : at least one port is requesting
//   winner     : chosen port (the one that did not go last on a tie)
module sdram_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = (&req) ? ~last_owner : req[1];
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM controller between two requesters using round-robin
// arbitration. Converts each port's req/gnt/done handshake into the
// controller's enable/ready protocol, latches the command at grant time,
// routes read data back to the owning port and aborts an access that the
// controller never finishes.
//   clk, rst            : clock, asynchronous active-high reset
//   pN_req/we/addr/
//   pN_wdata/pN_width   : port N command, held until pN_gnt
//   pN_gnt              : one-cycle pulse, command latched
//   pN_done             : one-cycle pulse, access finished
//   pN_rdata            : last read data returned to port N
//   mem_*               : controller command / response interface
//   busy                : an access is in flight
//   err                 : sticky watchdog timeout flag
//
// state | meaning
// IDLE  | no access in flight; grant when controller ready and a port requests
// ISSUE | enable asserted, waiting for ready to fall (controller accepted)
// BUSY  | enable dropped, waiting for ready to rise (access complete)
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_width,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_width,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_width,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              busy,
    output logic              err
);

    localparam int               TMR_W     = timer_width(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    arb_state_t       state;
    logic [TMR_W-1:0] timer;
    logic             owner;
    logic             last_owner;
    logic             pick_valid;
    logic             pick_winner;

    sdram_rr_pick u_pick (
        .req        ({p1_req, p0_req}),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            p0_gnt     <= 1'b0;
            p1_gnt     <= 1'b0;
            p0_done    <= 1'b0;
            p1_done    <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_width  <= '0;
            err        <= 1'b0;
        end else begin
            p0_gnt  <= 1'b0;
            p1_gnt  <= 1'b0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;

            case (state)
                IDLE: begin
                    // Holding off while ready is low also covers controller init.
                    if (mem_ready && pick_valid) begin
                        owner <= pick_winner;
                        if (pick_winner) begin
                            mem_write <= p1_we;
                            mem_addr  <= p1_addr;
                            mem_wdata <= p1_wdata;
                            mem_width <= p1_width;
                            p1_gnt    <= 1'b1;
                        end else begin
                            mem_write <= p0_we;
                            mem_addr  <= p0_addr;
                            mem_wdata <= p0_wdata;
                            mem_width <= p0_width;
                            p0_gnt    <= 1'b1;
                        end
                        mem_enable <= 1'b1;
                        timer      <= '0;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (!mem_ready) begin
                        mem_enable <= 1'b0;
                        timer      <= '0;
                        state      <= BUSY;
                    end else if (timer == TMR_LIMIT) begin
                        err        <= 1'b1;
                        mem_enable <= 1'b0;
                        p0_done    <= ~owner;
                        p1_done    <= owner;
                        last_owner <= owner;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                BUSY: begin
                    // A genuine completion wins over a coincident timeout.
                    if (mem_ready) begin
                        if (!mem_write) begin
                            if (owner) p1_rdata <= mem_rdata;
                            else       p0_rdata <= mem_rdata;
                        end
                        p0_done    <= ~owner;
                        p1_done    <= owner;
                        last_owner <= owner;
                        state      <= IDLE;
                    end else if (timer == TMR_LIMIT) begin
                        err        <= 1'b1;
                        mem_enable <= 1'b0;
                        p0_done    <= ~owner;
                        p1_done    <= owner;
                        last_owner <= owner;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
// tb_sdram_arbiter
// Directed bench for sdram_arbiter with a behavioural SDRAM controller,
// a cycle-level reference model of the arbitration rules and a per-cycle
// compare process, plus literal expectations on latencies and data.
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic [1:0]    p0_width = '0;
    logic          p0_gnt, p0_done;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic [1:0]    p1_width = '0;
    logic          p1_gnt, p1_done;
    logic [DW-1:0] p1_rdata;
    logic          mem_enable, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_width;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          busy, err;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_width(p0_width), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_width(p1_width), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_width(mem_width), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int order[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural SDRAM controller ----------------
    logic [DW-1:0] mem_img [logic [AW-1:0]];
    bit ctl_init  = 1'b1;
    bit ctl_stall = 1'b0;

    initial begin : ctl_model
        int phase, cnt;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        phase = 0; cnt = 0; a = '0; w = 1'b0; d = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_rdata = $urandom;   // read data only valid in the completion cycle
            if (ctl_init) begin
                mem_ready = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: begin
                        mem_ready = 1'b1;
                        if (mem_enable) begin
                            phase = 1; cnt = 0;
                            a = mem_addr; w = mem_write; d = mem_wdata;
                        end
                    end
                    1: begin
                        if (!mem_enable) phase = 0;
                        else begin
                            cnt++;
                            if (!ctl_stall && cnt >= 2) begin
                                mem_ready = 1'b0; phase = 2; cnt = 0;
                            end
                        end
                    end
                    default: begin
                        cnt++;
                        if (cnt >= 10) begin
                            mem_ready = 1'b1; phase = 0;
                            if (w) mem_img[a] = d;
                            else   mem_rdata = mem_img.exists(a) ? mem_img[a] : '0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- reference model ----------------
    int            m_owner = -1, m_last = 1, m_age = 0, m_w = 0;
    bit            m_acc = 1'b0, m_err = 1'b0, m_en = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [1:0]    m_width = '0;
    bit            m_gnt[2], m_done[2];
    logic [DW-1:0] m_rdata[2];

    task automatic model_release();
        m_done[m_owner] = 1'b1;
        m_en    = 1'b0;
        m_last  = m_owner;
        m_owner = -1;
    endtask

    initial begin : ref_model
        m_gnt[0] = 0; m_gnt[1] = 0; m_done[0] = 0; m_done[1] = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        forever begin
            @(posedge clk or posedge rst);
            m_gnt[0] = 0; m_gnt[1] = 0; m_done[0] = 0; m_done[1] = 0;
            if (rst) begin
                m_owner = -1; m_last = 1; m_age = 0; m_acc = 0; m_err = 0; m_en = 0;
                m_we = 0; m_addr = '0; m_wdata = '0; m_width = '0;
                m_rdata[0] = '0; m_rdata[1] = '0;
            end else if (m_owner < 0) begin
                if (mem_ready && (p0_req || p1_req)) begin
                    if (p0_req && p1_req) m_w = 1 - m_last;
                    else                  m_w = p0_req ? 0 : 1;
                    m_owner = m_w;
                    m_we    = m_w ? p1_we    : p0_we;
                    m_addr  = m_w ? p1_addr  : p0_addr;
                    m_wdata = m_w ? p1_wdata : p0_wdata;
                    m_width = m_w ? p1_width : p0_width;
                    m_gnt[m_w] = 1'b1;
                    m_en = 1'b1; m_acc = 1'b0; m_age = 0;
                end
            end else if (!m_acc && !mem_ready) begin
                m_acc = 1'b1; m_en = 1'b0; m_age = 0;
            end else if (m_acc && mem_ready) begin
                if (!m_we) m_rdata[m_owner] = mem_rdata;
                model_release();
            end else if (m_age >= TO) begin
                m_err = 1'b1;
                model_release();
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        chk("p0_gnt", p0_gnt, m_gnt[0]);
        chk("p1_gnt", p1_gnt, m_gnt[1]);
        chk("p0_done", p0_done, m_done[0]);
        chk("p1_done", p1_done, m_done[1]);
        chk("p0_rdata", p0_rdata, m_rdata[0]);
        chk("p1_rdata", p1_rdata, m_rdata[1]);
        chk("mem_enable", mem_enable, m_en);
        chk("busy", busy, m_owner >= 0);
        chk("err", err, m_err);
        chk("mem_write", mem_write, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_width", mem_width, m_width);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] wd);
        if (p == 0) begin
            p0_we = we; p0_addr = a; p0_wdata = d; p0_width = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = a; p1_wdata = d; p1_width = wd; p1_req = 1'b1;
        end
    endtask

    task automatic wait_gnt(input int p, output int at);
        int n = 0;
        while (!(p != 0 ? p1_gnt : p0_gnt) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("gnt_seen", p != 0 ? p1_gnt : p0_gnt, 1'b1);
        if (p == 0) p0_req = 1'b0; else p1_req = 1'b0;
        at = cyc;
        order.push_back(p);
    endtask

    task automatic wait_done(input int p, output int at);
        int n = 0;
        while (!(p != 0 ? p1_done : p0_done) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("done_seen", p != 0 ? p1_done : p0_done, 1'b1);
        at = cyc;
    endtask

    task automatic port_txn(input int p, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int g, dn;
        drive(p, we, a, d, p != 0 ? 2'b01 : WIDTH_32);
        wait_gnt(p, g);
        wait_done(p, dn);
        chk("txn_rdata", p != 0 ? p1_rdata : p0_rdata, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int g, d, c0;
        bit saw;
        logic [AW-1:0] a0[4] = '{25'h0800002, 25'h0000010, 25'h1FFFFFF, 25'h0000000};
        logic [DW-1:0] e0[4] = '{32'h12345600, 32'hA5A50001, 32'hFFFF0000, 32'h12345688};
        logic [AW-1:0] a1[4] = '{25'h0000100, 25'h0800002, 25'h0123456, 25'h0000020};
        logic [DW-1:0] e1[4] = '{32'h0BADF00D, 32'h12345600, 32'hCAFE0123, 32'h5555AAAA};
        int exp_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

        mem_img[25'h0800002] = 32'h12345600;
        mem_img[25'h0000010] = 32'hA5A50001;
        mem_img[25'h1FFFFFF] = 32'hFFFF0000;
        mem_img[25'h0000100] = 32'h0BADF00D;
        mem_img[25'h0123456] = 32'hCAFE0123;
        mem_img[25'h0000020] = 32'h5555AAAA;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_enable", mem_enable, 1'b0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_p1_rdata", p1_rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // controller still initialising: request must wait
        drive(0, 1'b1, 25'h0, 32'h12345688, WIDTH_32);
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (p0_gnt) saw = 1'b1;
        end
        chk("gnt_during_init", saw, 1'b0);
        @(posedge clk);
        ctl_init = 1'b0;
        #2;
        c0 = cyc;
        chk("ready_after_init", mem_ready, 1'b1);
        wait_gnt(0, g);
        chk("gnt_latency", g - c0, 1);
        chk("gnt_mem_enable", mem_enable, 1'b1);
        chk("gnt_mem_addr", mem_addr, 25'h0);
        chk("gnt_mem_wdata", mem_wdata, 32'h12345688);
        chk("gnt_mem_write", mem_write, 1'b1);
        chk("gnt_mem_width", mem_width, 2'b10);
        wait_done(0, d);
        chk("write_done_latency", d - g, 13);
        chk("write_p0_rdata", p0_rdata, 32'h0);
        chk("write_p1_rdata", p1_rdata, 32'h0);
        @(posedge clk); #1;
        chk("done_one_cycle", p0_done, 1'b0);

        // both ports from reset, strict alternation starting at port 0
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        order.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) port_txn(0, 1'b0, a0[i], 32'h0, e0[i]);
            end
            begin
                for (int j = 0; j < 4; j++) port_txn(1, 1'b0, a1[j], 32'h0, e1[j]);
            end
        join
        chk("order_len", order.size(), 8);
        for (int k = 0; k < 8; k++) chk("grant_order", order[k], exp_order[k]);

        // controller never drops ready: watchdog aborts the access
        ctl_stall = 1'b1;
        drive(0, 1'b0, 25'h1FFFFFF, 32'h0, WIDTH_32);
        wait_gnt(0, g);
        wait_done(0, d);
        chk("timeout_latency", d - g, 16);
        chk("timeout_err", err, 1'b1);
        chk("timeout_p0_rdata", p0_rdata, 32'h12345688);
        ctl_stall = 1'b0;
        port_txn(1, 1'b1, 25'h0000040, 32'h77770040, 32'h5555AAAA);
        port_txn(0, 1'b0, 25'h0000040, 32'h0, 32'h77770040);
        chk("err_sticky", err, 1'b1);

        // reset while the controller is busy
        drive(0, 1'b0, 25'h0123456, 32'h0, WIDTH_32);
        wait_gnt(0, g);
        c0 = 0;
        while (!(busy && !mem_enable && !mem_ready) && c0 < 50) begin
            @(posedge clk); #1; c0++;
        end
        chk("reached_busy", busy && !mem_enable && !mem_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_mem_enable", mem_enable, 1'b0);
        chk("arst_gnt", {p0_gnt, p1_gnt}, 2'b00);
        chk("arst_done", {p0_done, p1_done}, 2'b00);
        chk("arst_p0_rdata", p0_rdata, 32'h0);
        chk("arst_p1_rdata", p1_rdata, 32'h0);
        chk("arst_err", err, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (p0_done || p1_done) saw = 1'b1;
        end
        chk("no_done_after_rst", saw, 1'b0);
        order.delete();
        fork
            port_txn(0, 1'b0, 25'h0000010, 32'h0, 32'hA5A50001);
            port_txn(1, 1'b0, 25'h0000100, 32'h0, 32'h0BADF00D);
        join
        chk("post_rst_order_len", order.size(), 2);
        chk("post_rst_first", order[0], 0);
        chk("post_rst_second", order[1], 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
